// File: rtl/fft_pkg.sv
// Shared FFT types and sizes: frame geometry, collector states and the complex-bin record.
package fft_pkg;

    localparam int N_PTS = 32;
    localparam int RES_W = 17;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DROP
    } fft_state_e;

    typedef struct packed {
        logic [RES_W-1:0] re;
        logic [RES_W-1:0] im;
    } fft_bin_t;

endpackage

// File: rtl/fft_result_collector_if.sv
// Valid/ready bin stream leaving the FFT result collector.
interface fft_result_collector_if
    import fft_pkg::*;
#(
    parameter int W  = RES_W,
    parameter int IW = IDX_W
);

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_re;
    logic [W-1:0]  out_im;
    logic [IW-1:0] out_idx;
    logic          out_last;

    modport master (
        output out_valid, out_re, out_im, out_idx, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_re, out_im, out_idx, out_last,
        output out_ready
    );

endinterface

// File: rtl/fft_bin_buf.sv
// Frame store: separate real and imaginary arrays sharing one write address,
// each with a combinational read port.
module fft_bin_buf
    import fft_pkg::*;
#(
    parameter int N  = N_PTS,
    parameter int W  = RES_W,
    parameter int IW = IDX_W
) (
    input  logic          clk,
    input  logic          re_we,
    input  logic          im_we,
    input  logic [IW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [IW-1:0] raddr,
    output logic [W-1:0]  re_rdata,
    output logic [W-1:0]  im_rdata
);

    logic [W-1:0] re_mem [N];
    logic [W-1:0] im_mem [N];

    // NOTE: the arrays have no reset; every location is written before it is read, so they can map onto RAM.
    always_ff @(posedge clk) begin
        if (re_we) re_mem[waddr] <= wdata;
        if (im_we) im_mem[waddr] <= wdata;
    end

    assign re_rdata = re_mem[raddr];
    assign im_rdata = im_mem[raddr];

endmodule

// File: rtl/fft_result_collector.sv
// Buffers the serial FFT result stream (32 real then 32 imaginary words per frame)
// and replays it as complex bins in order on a valid/ready interface.
module fft_result_collector
    import fft_pkg::*;
#(
    parameter int N  = N_PTS,
    parameter int W  = RES_W,
    parameter int IW = IDX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   finish_i,
    input  logic [W-1:0]           answer_i,
    fft_result_collector_if.master bus,
    output logic                   frame_done,
    output logic                   overflow,
    input  logic                   ovf_clr
);

    localparam int CW = IW + 1;

    fft_state_e    state, state_nxt;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] rcnt;
    logic          held;

    logic          out_valid_q;
    logic          out_last_q;
    logic [W-1:0]  out_re_q;
    logic [W-1:0]  out_im_q;
    logic [IW-1:0] out_idx_q;

    logic [W-1:0]  re_rdata;
    logic [W-1:0]  im_rdata;
    logic          word_last, fire_last, drop_start, wr_en, avail, load;

    assign word_last  = finish_i && (wcnt == CW'(2 * N - 1));
    assign fire_last  = out_valid_q && bus.out_ready && out_last_q;
    assign drop_start = finish_i && (wcnt == '0) && held && !fire_last;
    assign wr_en      = finish_i && !drop_start && (state != DROP);

    // rcnt counts bins loaded into the output register; a frame still arriving
    // only exposes bins whose imaginary word has already been stored.
    assign avail = held ? !rcnt[IW]
                        : (state == COLLECT) && wcnt[IW] && ({1'b0, wcnt[IW-1:0]} > rcnt);
    assign load  = (!out_valid_q || bus.out_ready) && avail;

    fft_bin_buf #(.N(N), .W(W), .IW(IW)) u_buf (
        .clk      (clk),
        .re_we    (wr_en && !wcnt[IW]),
        .im_we    (wr_en && wcnt[IW]),
        .waddr    (wcnt[IW-1:0]),
        .wdata    (answer_i),
        .raddr    (rcnt[IW-1:0]),
        .re_rdata (re_rdata),
        .im_rdata (im_rdata)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (finish_i) state_nxt = COLLECT;
            // Bin N-1 cannot leave before its own word, so a completed frame always has bins pending.
            COLLECT: if (word_last) state_nxt = DRAIN;
            DRAIN: begin
                if (fire_last)     state_nxt = finish_i ? COLLECT : IDLE;
                else if (finish_i) state_nxt = DROP;
            end
            DROP:    if (word_last) state_nxt = (held && !fire_last) ? DRAIN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wcnt        <= '0;
            rcnt        <= '0;
            held        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= fire_last;

            if (finish_i) wcnt <= wcnt + CW'(1);

            if (fire_last)                         held <= 1'b0;
            else if (state == COLLECT && word_last) held <= 1'b1;

            if (fire_last) rcnt <= '0;
            else if (load) rcnt <= rcnt + CW'(1);

            if (load) begin
                out_valid_q <= 1'b1;
                out_re_q    <= re_rdata;
                out_im_q    <= im_rdata;
                out_idx_q   <= rcnt[IW-1:0];
                out_last_q  <= (rcnt[IW-1:0] == IW'(N - 1));
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (drop_start)   overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fft_result_collector.sv
// Self-checking bench: a frame-level model predicts every output each cycle;
// directed scenarios pin the model with literal bin values.
module tb_fft_result_collector;
    import fft_pkg::*;

    localparam int N  = N_PTS;
    localparam int W  = RES_W;
    localparam int IW = IDX_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         finish_i;
    logic [W-1:0] answer_i;
    logic         ovf_clr;
    logic         frame_done;
    logic         overflow;

    fft_result_collector_if #(.W(W), .IW(IW)) bus ();

    fft_result_collector #(.N(N), .W(W), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .finish_i   (finish_i),
        .answer_i   (answer_i),
        .bus        (bus),
        .frame_done (frame_done),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        fft_bin_t b;
        int       idx;
        bit       last;
    } xfer_t;

    fft_bin_t m_frame [N];
    fft_bin_t m_shown;
    int       m_wc, m_imag, m_cons, m_bin;
    bit       m_valid, m_fd, m_ovf, m_dropping;
    int       cyc = 0;
    xfer_t    seen_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wc = 0; m_imag = 0; m_cons = 0; m_bin = 0;
            m_valid = 0; m_fd = 0; m_ovf = 0; m_dropping = 0;
        end else begin
            bit xfer, last_xfer, pending;
            int imag_pre, cons_after;
            cyc++;
            if (bus.out_valid && bus.out_ready)
                seen_q.push_back('{b: '{re: bus.out_re, im: bus.out_im},
                                   idx: int'(bus.out_idx), last: bus.out_last});
            xfer       = m_valid && bus.out_ready;
            last_xfer  = xfer && (m_bin == N - 1);
            imag_pre   = m_imag;
            cons_after = m_cons + int'(xfer);
            m_fd       = last_xfer;
            if (last_xfer) begin
                m_cons = 0;
                m_imag = 0;
            end else begin
                m_cons = cons_after;
            end
            if (!m_valid || bus.out_ready) begin
                m_valid = !last_xfer && (cons_after < imag_pre);
                if (m_valid) begin
                    m_bin   = cons_after;
                    m_shown = m_frame[cons_after];
                end
            end
            if (ovf_clr) m_ovf = 0;
            if (finish_i) begin
                if (m_wc == 0) begin
                    pending    = (imag_pre == N) && !last_xfer;
                    m_dropping = pending;
                    if (pending) m_ovf = 1;
                end
                if (!m_dropping) begin
                    if (m_wc < N) m_frame[m_wc].re = answer_i;
                    else begin
                        m_frame[m_wc - N].im = answer_i;
                        m_imag = m_wc - N + 1;
                    end
                end
                m_wc = (m_wc + 1) % (2 * N);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 0;
    int first_valid_cyc = -1;
    int fd_cnt = 0;

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            check("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                check("out_re", bus.out_re, m_shown.re);
                check("out_im", bus.out_im, m_shown.im);
                check("out_idx", bus.out_idx, m_bin);
                check("out_last", bus.out_last, m_bin == N - 1);
            end
            check("frame_done", frame_done, m_fd);
            check("overflow", overflow, m_ovf);
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (frame_done) fd_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    int ready_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random, 3 never, 4 until stop_at transfers
    int stop_at    = 0;
    int phase      = 0;
    bit clr_rand   = 0;
    bit force_clr  = 0;
    int imag0_cyc  = 0;

    task automatic cycle(input bit f, input logic [W-1:0] w);
        finish_i = f;
        answer_i = f ? w : W'($urandom);
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (phase % 3 == 0);
            2:       bus.out_ready = 1'($urandom % 2);
            3:       bus.out_ready = 1'b0;
            default: bus.out_ready = (seen_q.size() < stop_at);
        endcase
        phase++;
        ovf_clr = force_clr || (clr_rand && ($urandom % 8 == 0));
        @(negedge clk);
    endtask

    task automatic send_frame(input int re_base, input int im_base, input int gap, input bit rnd);
        for (int k = 0; k < 2 * N; k++) begin
            logic [W-1:0] d;
            int g;
            d = (k < N) ? W'(re_base + k) : W'(im_base + k - N);
            if (rnd) d = W'($urandom);
            if (k == N) imag0_cyc = cyc;
            cycle(1'b1, d);
            g = (gap < 0) ? int'($urandom % 3) : gap;
            repeat (g) cycle(1'b0, '0);
        end
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while ((m_valid || m_imag != 0) && i < budget) begin
            cycle(1'b0, '0);
            i++;
        end
        if (i >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: still pending after %0d cycles", budget);
        end
        repeat (2) cycle(1'b0, '0);
        check("idle_after_drain", bus.out_valid, 0);
    endtask

    task automatic check_seen(input string tag, input int base, input int re0, input int im0);
        for (int k = 0; k < N; k++) begin
            check({tag, "_re"}, seen_q[base + k].b.re, W'(re0 + k));
            check({tag, "_im"}, seen_q[base + k].b.im, W'(im0 + k));
            check({tag, "_idx"}, seen_q[base + k].idx, k);
            check({tag, "_last"}, seen_q[base + k].last, k == N - 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; finish_i = 1'b0; answer_i = '0; ovf_clr = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.out_valid, 0);
        check("rst_re", bus.out_re, 0);
        check("rst_im", bus.out_im, 0);
        check("rst_idx", bus.out_idx, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        cmp_en = 1'b1;
        cycle(1'b0, '0);

        // Back-to-back frame, always ready
        seen_q.delete(); first_valid_cyc = -1; fd_cnt = 0; ready_mode = 0;
        send_frame(100, 200, 0, 0);
        drain(200);
        check("t1_latency", first_valid_cyc - imag0_cyc, 2);
        check("t1_count", seen_q.size(), N);
        if (seen_q.size() == N) check_seen("t1", 0, 100, 200);
        check("t1_frame_done_pulses", fd_cnt, 1);

        // Backpressure 1,0,0 pattern, random data
        seen_q.delete(); ready_mode = 1;
        send_frame(0, 0, 0, 1);
        drain(400);
        check("t2_count", seen_q.size(), N);
        for (int k = 0; k < N && k < seen_q.size(); k++) check("t2_order", seen_q[k].idx, k);

        // Gapped input, one word every third cycle
        seen_q.delete(); ready_mode = 0;
        send_frame(100, 200, 2, 0);
        drain(200);
        check("t3_count", seen_q.size(), N);
        if (seen_q.size() == N) check_seen("t3", 0, 100, 200);

        // Overflow: stall after bin 5, second frame arrives and is dropped
        seen_q.delete(); ready_mode = 4; stop_at = 6;
        send_frame(300, 400, 0, 0);
        for (int k = 0; k < 2 * N; k++) begin
            force_clr = (k == 0);
            cycle(1'b1, W'(500 + k));
        end
        force_clr = 1'b0;
        check("t4_overflow_set", overflow, 1);
        check("t4_stalled_count", seen_q.size(), 6);
        ready_mode = 0;
        drain(200);
        check("t4_count", seen_q.size(), N);
        if (seen_q.size() == N) check_seen("t4", 0, 300, 400);
        check("t4_overflow_sticky", overflow, 1);
        force_clr = 1'b1;
        cycle(1'b0, '0);
        force_clr = 1'b0;
        check("t4_overflow_clr", overflow, 0);

        // Exact boundary: first word of next frame meets the bin N-1 transfer
        seen_q.delete(); ready_mode = 0;
        send_frame(600, 700, 0, 0);
        begin
            int w = 0;
            while (!(bus.out_valid && bus.out_last) && w < 50) begin
                cycle(1'b0, '0);
                w++;
            end
            if (w >= 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL t5_wait_last: bin N-1 never presented");
            end
        end
        send_frame(800, 900, 0, 0);
        drain(200);
        check("t5_overflow", overflow, 0);
        check("t5_count", seen_q.size(), 2 * N);
        if (seen_q.size() == 2 * N) begin
            check_seen("t5a", 0, 600, 700);
            check_seen("t5b", N, 800, 900);
        end

        // Reset after 40 words, then a fresh frame
        ready_mode = 3;
        for (int k = 0; k < 40; k++) cycle(1'b1, W'(17'h10000 | k));
        check("t6_pre_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        finish_i = 1'b0;
        #1;
        check("t6_valid", bus.out_valid, 0);
        check("t6_re", bus.out_re, 0);
        check("t6_im", bus.out_im, 0);
        check("t6_idx", bus.out_idx, 0);
        check("t6_last", bus.out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_q.delete(); ready_mode = 0;
        send_frame(1000, 1100, 0, 0);
        drain(200);
        check("t6_count", seen_q.size(), N);
        if (seen_q.size() == N) check_seen("t6", 0, 1000, 1100);

        // Randomized traffic: random data, gaps, ready and clears
        ready_mode = 2; clr_rand = 1'b1;
        repeat (8) begin
            send_frame(0, 0, -1, 1);
            repeat ($urandom % 20) cycle(1'b0, '0);
        end
        clr_rand = 1'b0; ready_mode = 0;
        drain(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
